// File: rtl/trojan_chk_pkg.sv
// trojan_chk_pkg: shared state encoding and MISR constants for the response checker.
package trojan_chk_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
endpackage

// File: rtl/response_misr16.sv
// response_misr16: 16-bit multiple-input signature register compressing checked responses.
module response_misr16
  import trojan_chk_pkg::*;
(
  input  logic        CK,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] sig
);
  always_ff @(posedge CK or negedge reset)
    if (!reset) sig <= MISR_SEED;
    else if (clear) sig <= MISR_SEED;
    else if (en) sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0) ^ data;
endmodule

// File: rtl/trojan_response_checker.sv
// trojan_response_checker: loads a golden response table, then checks DUT samples against it
// with mismatch counting, first-fail capture, coverage tracking and a MISR signature.
module trojan_response_checker
  import trojan_chk_pkg::*;
#(
  parameter int N_W   = 3,
  parameter int R_W   = 1,
  parameter int CNT_W = 8
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             gld_valid,
  input  logic [R_W-1:0]   gld_data,
  output logic             gld_ready,
  input  logic             smp_valid,
  input  logic [N_W-1:0]   smp_pat,
  input  logic [R_W-1:0]   smp_resp,
  output logic             smp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_fail_vld,
  output logic [N_W-1:0]   first_fail_pat,
  output logic [15:0]      signature
);
  localparam int N = 2 ** N_W;
  localparam logic [N-1:0] ONE = N'(1);
  state_t state, state_nx;
  logic [R_W-1:0] golden [N];
  logic [N_W-1:0] ptr;
  logic [N-1:0]   cov, cov_nx;
  logic           clr, gld_hs, smp_hs, mis;
  assign gld_ready = state == LOAD;
  assign smp_ready = state == RUN;
  assign busy      = gld_ready | smp_ready;
  assign done      = state == DONE;
  assign pass      = done && mismatch_cnt == '0;
  assign clr       = start && (state == IDLE || state == DONE);
  assign gld_hs    = gld_valid & gld_ready;
  assign smp_hs    = smp_valid & smp_ready;
  assign mis       = smp_resp != golden[smp_pat];
  assign cov_nx    = cov | (ONE << smp_pat);
  always_ff @(posedge CK or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (clr) state_nx = LOAD;
    else if (gld_hs && &ptr) state_nx = RUN;
    else if (smp_hs && &cov_nx) state_nx = DONE;
  end
  always_ff @(posedge CK or negedge reset)
    if (!reset) begin
      ptr            <= '0;
      cov            <= '0;
      mismatch_cnt   <= '0;
      first_fail_vld <= 1'b0;
      first_fail_pat <= '0;
      for (int i = 0; i < N; i++) golden[i] <= '0;
    end else if (clr) begin
      ptr            <= '0;
      cov            <= '0;
      mismatch_cnt   <= '0;
      first_fail_vld <= 1'b0;
      first_fail_pat <= '0;
    end else begin
      if (gld_hs) begin
        golden[ptr] <= gld_data;
        ptr         <= ptr + N_W'(1);
      end
      if (smp_hs) begin
        cov <= cov_nx;
        // count saturates; first-fail capture is sticky for the whole run
        if (mis && ~&mismatch_cnt) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (mis && !first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_pat <= smp_pat;
        end
      end
    end
  response_misr16 u_misr (
    .CK    (CK),
    .reset (reset),
    .clear (clr),
    .en    (smp_hs),
    .data  (16'({smp_pat, smp_resp})),
    .sig   (signature)
  );
endmodule

// File: tb/tb_trojan_response_checker.sv
// tb_trojan_response_checker: directed runs against a default checker and a 2-bit-counter checker.
module tb_trojan_response_checker;
  logic CK = 0, reset = 0, start = 0, gld_valid = 0, smp_valid = 0;
  logic [0:0] gld_data = '0, smp_resp = '0;
  logic [2:0] smp_pat = '0;
  logic gld_ready, smp_ready, busy, done, pass, first_fail_vld;
  logic [7:0] mismatch_cnt;
  logic [2:0] first_fail_pat;
  logic [15:0] signature;
  logic s_gld_ready, s_smp_ready, s_busy, s_done, s_pass, s_ffv;
  logic [1:0] s_cnt;
  logic [2:0] s_ffp;
  logic [15:0] s_sig;
  logic [15:0] esig;
  logic [7:0] g = 8'h96;
  int n_chk = 0, n_fail = 0;

  always #5 CK = ~CK;

  trojan_response_checker dut (
    .CK(CK), .reset(reset), .start(start), .gld_valid(gld_valid), .gld_data(gld_data),
    .gld_ready(gld_ready), .smp_valid(smp_valid), .smp_pat(smp_pat), .smp_resp(smp_resp),
    .smp_ready(smp_ready), .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_pat(first_fail_pat), .signature(signature)
  );

  trojan_response_checker #(.CNT_W(2)) dut_sat (
    .CK(CK), .reset(reset), .start(start), .gld_valid(gld_valid), .gld_data(gld_data),
    .gld_ready(s_gld_ready), .smp_valid(smp_valid), .smp_pat(smp_pat), .smp_resp(smp_resp),
    .smp_ready(s_smp_ready), .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch_cnt(s_cnt),
    .first_fail_vld(s_ffv), .first_fail_pat(s_ffp), .signature(s_sig)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr_f(logic [15:0] s, logic [2:0] p, logic r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {12'h0, p, r};
  endfunction

  task automatic do_start;
    start = 1;
    @(negedge CK);
    start = 0;
    esig = 16'hFFFF;
  endtask

  // optional idle gaps between golden beats; optional stale sample held during the load
  task automatic load(input bit gap, input bit hold);
    smp_valid = hold;
    smp_pat = 3'd0;
    smp_resp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gld_valid = 1;
      gld_data = g[i];
      @(negedge CK);
      gld_valid = 0;
      if (i == 7) smp_valid = 0;
      else if (gap) @(negedge CK);
      if (hold && i == 3) begin
        chk("smp_ready_in_load", 32'(smp_ready), 32'd0);
        chk("cnt_in_load", 32'(mismatch_cnt), 32'd0);
      end
      if (gap && i == 6) chk("gld_ready_before_8th", 32'(gld_ready), 32'd1);
    end
    chk("run_after_load", 32'(smp_ready), 32'd1);
  endtask

  task automatic feed(input logic [2:0] p, input logic r);
    smp_valid = 1;
    smp_pat = p;
    smp_resp = r;
    @(negedge CK);
    smp_valid = 0;
    esig = misr_f(esig, p, r);
  endtask

  task automatic clean_run(input string tag);
    for (int p = 0; p < 8; p++) begin
      feed(3'(p), g[p]);
      if (p == 0) chk({tag, "_sig_first"}, 32'(signature), 32'h0000EFDF);
      if (p == 6) chk({tag, "_done_before_last"}, 32'(done), 32'd0);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_pass"}, 32'(pass), 32'd1);
    chk({tag, "_cnt"}, 32'(mismatch_cnt), 32'd0);
    chk({tag, "_ffv"}, 32'(first_fail_vld), 32'd0);
    chk({tag, "_sig"}, 32'(signature), 32'(esig));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge CK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_gld_ready", 32'(gld_ready), 32'd0);
    chk("rst_smp_ready", 32'(smp_ready), 32'd0);
    chk("rst_sig", 32'(signature), 32'hFFFF);
    chk("rst_cnt", 32'(mismatch_cnt), 32'd0);
    reset = 1;
    @(negedge CK);
    chk("idle_gld_ready", 32'(gld_ready), 32'd0);

    // clean run with gapped golden load and a sample held during LOAD
    do_start;
    chk("load_busy", 32'(busy), 32'd1);
    load(1'b1, 1'b1);
    clean_run("clean");

    // single fault on pattern 5; start in RUN must be ignored
    do_start;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_sig", 32'(signature), 32'hFFFF);
    load(1'b0, 1'b0);
    start = 1;
    @(negedge CK);
    start = 0;
    chk("start_ignored_run", 32'(smp_ready), 32'd1);
    for (int p = 0; p < 8; p++) feed(3'(p), g[p] ^ (p == 5));
    chk("fault_cnt", 32'(mismatch_cnt), 32'd1);
    chk("fault_ffv", 32'(first_fail_vld), 32'd1);
    chk("fault_ffp", 32'(first_fail_pat), 32'd5);
    chk("fault_pass", 32'(pass), 32'd0);
    chk("fault_done", 32'(done), 32'd1);
    chk("fault_sig", 32'(signature), 32'(esig));

    // duplicates and reordering: 7,7,0..6, wrong only on the first 7
    do_start;
    load(1'b0, 1'b0);
    feed(3'd7, ~g[7]);
    feed(3'd7, g[7]);
    for (int p = 0; p < 7; p++) begin
      feed(3'(p), g[p]);
      if (p == 5) chk("dup_done_before_6", 32'(done), 32'd0);
    end
    chk("dup_done", 32'(done), 32'd1);
    chk("dup_cnt", 32'(mismatch_cnt), 32'd1);
    chk("dup_ffp", 32'(first_fail_pat), 32'd7);
    chk("dup_sig", 32'(signature), 32'(esig));

    // all responses inverted: 8-bit counter reaches 8, 2-bit counter saturates at 3
    do_start;
    load(1'b0, 1'b0);
    for (int p = 0; p < 8; p++) feed(3'(p), ~g[p]);
    chk("inv_cnt", 32'(mismatch_cnt), 32'd8);
    chk("sat_cnt", 32'(s_cnt), 32'd3);
    chk("sat_ffp", 32'(s_ffp), 32'd0);
    chk("sat_pass", 32'(s_pass), 32'd0);
    chk("sat_done", 32'(s_done), 32'd1);

    // reset mid-run after 4 samples, then a full clean run
    do_start;
    load(1'b0, 1'b0);
    for (int p = 0; p < 4; p++) feed(3'(p), g[p] ^ (p == 2));
    chk("mid_cnt_pre", 32'(mismatch_cnt), 32'd1);
    reset = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sig", 32'(signature), 32'hFFFF);
    chk("mid_rst_cnt", 32'(mismatch_cnt), 32'd0);
    @(negedge CK);
    reset = 1;
    @(negedge CK);
    do_start;
    load(1'b0, 1'b0);
    clean_run("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
